sum_uart_tx: RTL and testbench
==============================

SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_i  input  8  byte to transmit (running-sum output of the upstream stage).
REQ-005 valid_i  input  1  data_i valid.
REQ-006 ready_o  output  1  block can accept a byte this cycle.
REQ-007 tx_o  output  1  serial line, idle high, registered.
REQ-008 busy_o  output  1  frame in progress.

Function
REQ-009 Transfer SHALL occur on a rising edge where valid_i && ready_o; data_i captured into an 8-bit shift register.
REQ-010 ready_o SHALL equal (state == IDLE) && !rst, combinationally; valid_i with ready_o low SHALL be ignored, with no buffering.
REQ-011 busy_o SHALL equal (state != IDLE).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is reachable only per REQ-021.
REQ-013 IDLE->START on transfer; tx_o SHALL go low on the cycle after the transfer edge, giving 1-cycle latency.
REQ-014 Each of START, DATA-bit, PARITY and STOP SHALL hold tx_o for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state or bit change.
REQ-015 DATA SHALL send 8 bits LSB first, using a 3-bit bit index that wraps 7->0 on exit to the next state.
REQ-016 STOP SHALL drive tx_o high, then return to IDLE; minimum gap between frames is 1 clk (the IDLE cycle), so frame period = 10*CLKS_PER_BIT + 1 without parity.
REQ-017 Valid_i asserted continuously SHALL produce back-to-back frames with exactly the REQ-016 period.
REQ-018 data_i changes after transfer SHALL NOT affect the frame in flight.
REQ-019 The baud counter width SHALL be $clog2(CLKS_PER_BIT); terminal count is CLKS_PER_BIT-1, with no wrap beyond it.

Reset
REQ-020 rst high at an edge SHALL force: state IDLE, tx_o 1, busy_o 0, baud counter 0, bit index 0, shift register 0; ready_o SHALL be 0 while rst is high and 1 on the first cycle after; reset mid-frame SHALL abort the frame, with tx_o high on the next cycle.

Configuration
REQ-021 With macro SUM_UART_PARITY_EN defined, DATA->PARITY->STOP SHALL be followed, sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame period of 11*CLKS_PER_BIT + 1; without it, DATA->STOP directly and no parity logic SHALL be synthesized.

Structure
REQ-022 Package sum_uart_pkg SHALL hold the state enum type (tx_state_t), DATA_BITS = 8, and the frame-length constants for both parity options.
REQ-023 One sub-module, sum_uart_baud (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick on terminal count), SHALL provide bit timing; the FSM and shift register stay in sum_uart_tx.

Verification (CLKS_PER_BIT = 4)
REQ-024 Reset, then drive valid_i=1 with data_i=0xA5 for one cycle -> ready_o drops the next cycle; tx_o = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; ready_o back to 1 at cycle 41.
REQ-025 With SUM_UART_PARITY_EN defined, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; frame period 45 cycles.
REQ-026 Hold valid_i=1 with data_i stepping 0x00,0x02,0x04 on each transfer -> three contiguous frames 41 cycles apart; each frame's bits match the byte present at its transfer edge.
REQ-027 Pulse valid_i during DATA with data_i=0xFF -> byte ignored; frame in flight unchanged; no extra frame.
REQ-028 Assert rst for 1 cycle at the 3rd data bit -> tx_o=1, busy_o=0 next cycle, ready_o=1 the cycle after rst deasserts; a following send of 0x3C transmits correctly.

Source files
------------

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum_uart_tx serial transmitter.
// Frame-length constants cover both builds (with and without SUM_UART_PARITY_EN).
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_NO_PARITY = DATA_BITS + 2;
  localparam int FRAME_BITS_PARITY    = DATA_BITS + 3;

  // Clocks from one transfer edge to the next when valid is held high.
  function automatic int frame_period(input int clks_per_bit, input bit parity_en);
    return (parity_en ? FRAME_BITS_PARITY : FRAME_BITS_NO_PARITY) * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/sum_uart_tx_if.sv
// Byte handshake between the running-sum stage (master) and the UART transmitter (slave).
interface sum_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input  ready_o);
  modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

// File: rtl/sum_uart_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, holds at the terminal count and
// flags it with tick; clear restarts the count on every state or bit change.
module sum_uart_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            W  = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0]  TC = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != TC) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == TC);

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for the running-sum byte stream: 8N1 frames, LSB first.
// Define SUM_UART_PARITY_EN to insert an even-parity bit between data and stop.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_uart_tx_if.slave         s_if,
  output logic                 tx_o,
  output logic                 busy_o
);

  tx_state_t  r_state;
  logic       r_tx;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
`ifdef SUM_UART_PARITY_EN
  logic       r_parity;
`endif

  logic w_tick;
  logic w_clear;
  logic w_transfer;

  assign s_if.ready_o = (r_state == IDLE) && !rst;
  assign w_transfer   = s_if.valid_i && s_if.ready_o;
  // Counter sits at zero while idle and restarts each time a bit period ends.
  assign w_clear      = (r_state == IDLE) || w_tick;

  sum_uart_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // NOTE: synchronous reset puts every register, including the shift register,
  // into a known state so an aborted frame leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef SUM_UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_shift <= s_if.data_i;
            r_tx    <= 1'b0;
            r_state <= START;
`ifdef SUM_UART_PARITY_EN
            r_parity <= ^s_if.data_i;
`endif
          end
        end

        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
              r_bit_idx <= '0;
`ifdef SUM_UART_PARITY_EN
              r_tx      <= r_parity;
              r_state   <= PARITY;
`else
              r_tx      <= 1'b1;
              r_state   <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end
        end

`ifdef SUM_UART_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
`endif

        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx at CLKS_PER_BIT = 4; builds with or
// without SUM_UART_PARITY_EN and predicts the serial waveform from the byte.
module tb_sum_uart_tx;
  import sum_uart_pkg::*;

  localparam int CPB = 4;
`ifdef SUM_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? FRAME_BITS_PARITY : FRAME_BITS_NO_PARITY;

  logic clk;
  logic rst;
  logic tx;
  logic busy;
  int   total;
  int   bad;

  sum_uart_tx_if u_if ();

  sum_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_if   (u_if),
    .tx_o   (tx),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for bit slot idx of the frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR && idx == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at an idle negedge. Sends d, then presents nxt on data_i after the
  // transfer; keep holds valid high; inject_at >= 0 pulses a 0xFF mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] nxt,
                            input bit keep, input int inject_at);
    check("ready_before_send", u_if.ready_o, 1);
    u_if.valid_i = 1'b1;
    u_if.data_i  = d;
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge clk);
      check($sformatf("tx_%02h_slot%0d", d, k / CPB), tx, exp_bit(d, k / CPB));
      check("busy_in_frame", busy, 1);
      check("ready_in_frame", u_if.ready_o, 0);
      if (k == 0) begin
        if (!keep) u_if.valid_i = 1'b0;
        u_if.data_i = nxt;
      end
      if (inject_at >= 0 && k == inject_at) begin
        u_if.valid_i = 1'b1;
        u_if.data_i  = 8'hFF;
      end else if (inject_at >= 0 && k == inject_at + 1) begin
        u_if.valid_i = 1'b0;
      end
    end
    @(negedge clk);
    check("gap_tx", tx, 1);
    check("gap_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] rb;
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    u_if.valid_i = 1'b0;
    u_if.data_i  = 8'h00;

    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", u_if.ready_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", u_if.ready_o, 1);
    check("period_const", frame_period(CPB, PAR), NB * CPB + 1);

    // Single frames, including the parity reference bytes.
    send_frame(8'hA5, 8'($urandom), 1'b0, -1);
    send_frame(8'h07, 8'($urandom), 1'b0, -1);

    // Valid held high: back-to-back frames one idle cycle apart.
    send_frame(8'h00, 8'h02, 1'b1, -1);
    send_frame(8'h02, 8'h04, 1'b1, -1);
    send_frame(8'h04, 8'($urandom), 1'b0, -1);

    // Byte offered during DATA must be dropped without a follow-on frame.
    rb = 8'($urandom);
    send_frame(rb, 8'($urandom), 1'b0, 3 * CPB + 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_extra_frame_busy", busy, 0);
      check("no_extra_frame_tx", tx, 1);
    end

    // Reset during the third data bit aborts the frame.
    u_if.valid_i = 1'b1;
    u_if.data_i  = 8'h5A;
    for (int k = 0; k <= 3 * CPB; k++) begin
      @(negedge clk);
      check("abort_frame_tx", tx, exp_bit(8'h5A, k / CPB));
      if (k == 0) u_if.valid_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high", tx, 1);
    check("abort_busy_low", busy, 0);
    check("abort_ready_in_reset", u_if.ready_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", u_if.ready_o, 1);
    send_frame(8'h3C, 8'($urandom), 1'b0, -1);

    // Random bytes with data_i scrambled after each transfer.
    for (int n = 0; n < 4; n++) begin
      send_frame(8'($urandom), 8'($urandom), 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
